// File: rtl/buffer_column_sequencer_pkg.sv
// Shared encodings for the interpolation buffer controllers.
//   SEL_ZERO  : column code that presents an all-zero column
//   SEL_FIRST : code of the first real column
//   state_t   : controller FSM states
package buffer_column_sequencer_pkg;

  localparam int SEL_ZERO  = 0;
  localparam int SEL_FIRST = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AUTO = 2'd1,
    MAN  = 2'd2
  } state_t;

endpackage

// File: rtl/buffer_column_sequencer_if.sv
// Valid/ready column stream from the sequencer to the vertical filter.
//   out_valid : data_out/col_idx/last are valid
//   out_ready : consumer can accept the beat
//   data_out  : one column of samples
//   col_idx   : code of the column presented (0 for a zero column)
//   last      : final beat of the current transfer
interface buffer_column_sequencer_if #(
  parameter int COL_W = 99,
  parameter int SEL_W = 3
);

  logic             out_valid;
  logic             out_ready;
  logic [COL_W-1:0] data_out;
  logic [SEL_W-1:0] col_idx;
  logic             last;

  modport master (
    output out_valid, data_out, col_idx, last,
    input  out_ready
  );

  modport slave (
    input  out_valid, data_out, col_idx, last,
    output out_ready
  );

endinterface

// File: rtl/buffer_column_sequencer_column_select_mux.sv
// Combinational N_COLS-way column selector.
//   cols : flat column bus, code k (1-based) at bits [k*COL_W-1 -: COL_W]
//   sel  : column code; 0 or any code above N_COLS yields zeros
//   col  : selected column
module column_select_mux #(
  parameter int N_COLS = 4,
  parameter int COL_W  = 99,
  parameter int SEL_W  = 3
) (
  input  logic [N_COLS*COL_W-1:0] cols,
  input  logic [SEL_W-1:0]        sel,
  output logic [COL_W-1:0]        col
);

  // Codes are 1-based so that code 0 is naturally the zero column.
  always_comb begin
    col = '0;
    for (int k = 1; k <= N_COLS; k++) begin
      if (sel == SEL_W'(k)) begin
        col = cols[(k-1)*COL_W +: COL_W];
      end
    end
  end

endmodule

// File: rtl/buffer_column_sequencer.sv
// Column sequencer between the transposed buffer and the vertical filter.
// Captures all columns in one load beat, then streams them out either as
// a forward/reverse scan or as a single manually selected column.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   load       : capture data_in (honoured only when idle and start low)
//   data_in    : flat column bus, column k at [k*COL_W-1 -: COL_W]
//   start      : begin a transfer; mode/reverse/select sampled here
//   mode       : 0 = auto scan, 1 = single manual column
//   reverse    : auto scan order, 0 = 1..N_COLS, 1 = N_COLS..1
//   select     : manual column code
//   busy       : controller is not idle
//   out_if     : valid/ready column stream (master side)
module buffer_column_sequencer
  import buffer_column_sequencer_pkg::*;
#(
  parameter  int SAMPLE_BITS = 9,
  parameter  int SAMPLES     = 11,
  parameter  int N_COLS      = 4,
  parameter  int SEL_W       = 3,
  localparam int COL_W       = SAMPLES * SAMPLE_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [N_COLS*COL_W-1:0] data_in,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    reverse,
  input  logic [SEL_W-1:0]        select,
  output logic                    busy,
  buffer_column_sequencer_if.master out_if
);

  localparam logic [SEL_W-1:0] CODE_ZERO  = SEL_W'(SEL_ZERO);
  localparam logic [SEL_W-1:0] CODE_FIRST = SEL_W'(SEL_FIRST);
  localparam logic [SEL_W-1:0] CODE_LAST  = SEL_W'(N_COLS);

  state_t                  state;
  logic [N_COLS*COL_W-1:0] store;
  logic                    loaded;
  logic                    rev_q;

  logic                    accept;
  logic                    man_valid;
  logic [SEL_W-1:0]        first_sel;
  logic [SEL_W-1:0]        next_sel;
  logic [SEL_W-1:0]        end_sel;
  logic [SEL_W-1:0]        mux_sel;
  logic [COL_W-1:0]        mux_col;

  assign accept    = out_if.out_valid & out_if.out_ready;
  assign man_valid = (select >= CODE_FIRST) && (select <= CODE_LAST);
  assign first_sel = reverse ? CODE_LAST : CODE_FIRST;
  assign next_sel  = rev_q ? (out_if.col_idx - CODE_FIRST) : (out_if.col_idx + CODE_FIRST);
  assign end_sel   = rev_q ? CODE_FIRST : CODE_LAST;

  // The mux always feeds the output register with whatever column the
  // FSM will present after the coming edge; zero when nothing new loads.
  always_comb begin
    mux_sel = CODE_ZERO;
    case (state)
      IDLE: if (start && loaded) mux_sel = mode ? select : first_sel;
      AUTO: if (accept && !out_if.last) mux_sel = next_sel;
      default: mux_sel = CODE_ZERO;
    endcase
  end

  column_select_mux #(
    .N_COLS (N_COLS),
    .COL_W  (COL_W),
    .SEL_W  (SEL_W)
  ) u_column_select_mux (
    .cols (store),
    .sel  (mux_sel),
    .col  (mux_col)
  );

  // Single FSM with registered outputs. The store is only writable in
  // IDLE, so a transfer always streams a coherent snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      store            <= '0;
      loaded           <= 1'b0;
      rev_q            <= 1'b0;
      busy             <= 1'b0;
      out_if.out_valid <= 1'b0;
      out_if.data_out  <= '0;
      out_if.col_idx   <= CODE_ZERO;
      out_if.last      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && loaded) begin
            busy             <= 1'b1;
            out_if.out_valid <= 1'b1;
            out_if.data_out  <= mux_col;
            if (!mode) begin
              state          <= AUTO;
              rev_q          <= reverse;
              out_if.col_idx <= first_sel;
              out_if.last    <= 1'b0;
            end else begin
              state          <= MAN;
              out_if.col_idx <= man_valid ? select : CODE_ZERO;
              out_if.last    <= 1'b1;
            end
          end else if (load && !start) begin
            store  <= data_in;
            loaded <= 1'b1;
          end
        end
        AUTO: begin
          if (accept) begin
            if (out_if.last) begin
              state            <= IDLE;
              busy             <= 1'b0;
              out_if.out_valid <= 1'b0;
              out_if.data_out  <= '0;
              out_if.col_idx   <= CODE_ZERO;
              out_if.last      <= 1'b0;
            end else begin
              out_if.col_idx  <= next_sel;
              out_if.data_out <= mux_col;
              out_if.last     <= (next_sel == end_sel);
            end
          end
        end
        MAN: begin
          if (accept) begin
            state            <= IDLE;
            busy             <= 1'b0;
            out_if.out_valid <= 1'b0;
            out_if.data_out  <= '0;
            out_if.col_idx   <= CODE_ZERO;
            out_if.last      <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          busy             <= 1'b0;
          out_if.out_valid <= 1'b0;
          out_if.last      <= 1'b0;
        end
      endcase
    end
  end

endmodule
